// File: rtl/spi_dac_arbiter.sv
// -----------------------------------------------------------------------------
// spi_dac_arbiter
//
// Shares one SPI write master between two DAC requesters (0: VCO ramp,
// 1: AGC). A granted word is registered onto spi_wdat, a one-cycle spi_load
// strobe kicks the master, and the arbiter then follows spi_csn through the
// start (falling) and end (rising) of the transfer before acking the owner.
// A watchdog aborts transfers that stall, acks the owner anyway and raises
// a sticky err flag.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   req0/wdat0/ack0   requester 0: level request, data word, completion pulse
//   req1/wdat1/ack1   requester 1: same handshake
//   spi_wdat          word presented to the SPI master (held for the transfer)
//   spi_load          one-cycle load strobe to the SPI master
//   spi_csn           chip select from the SPI master, low = transfer active
//   busy              high whenever the arbiter is not idle
//   err               sticky timeout flag
// -----------------------------------------------------------------------------
module spi_dac_arbiter #(
    parameter int DW      = 13,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic [DW-1:0] wdat0,
    output logic          ack0,
    input  logic          req1,
    input  logic [DW-1:0] wdat1,
    output logic          ack1,
    output logic [DW-1:0] spi_wdat,
    output logic          spi_load,
    input  logic          spi_csn,
    output logic          busy,
    output logic          err
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOAD       = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_DONE       = 3'd4;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [2:0]    r_state;
    logic          r_load;
    logic [DW-1:0] r_wdat;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_busy;
    logic          r_err;
    logic          r_last_grant;
    logic          r_owner;
    logic [15:0]   r_cnt;

    logic          w_grant1;
    logic [DW-1:0] w_grant_dat;
    logic          w_waiting;
    logic          w_started;
    logic          w_finished;
    logic          w_timeout;
    logic          w_to_done;

    // Requester 1 wins only when it is alone or requester 0 had the last turn;
    // reset leaves last_grant at 1 so requester 0 wins the first tie.
    assign w_grant1    = req1 & (~req0 | ~r_last_grant);
    assign w_grant_dat = w_grant1 ? wdat1 : wdat0;

    assign w_waiting  = (r_state == S_WAIT_START) || (r_state == S_WAIT_DONE);
    assign w_started  = (r_state == S_WAIT_START) && !spi_csn;
    assign w_finished = (r_state == S_WAIT_DONE) && spi_csn;
    // A csn edge seen on the last allowed cycle still counts as progress,
    // so the watchdog only fires when nothing happened.
    assign w_timeout  = w_waiting && (r_cnt == TO_LAST) && !w_started && !w_finished;
    assign w_to_done  = w_finished || w_timeout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_load       <= 1'b0;
            r_wdat       <= '0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_load <= 1'b0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        r_owner <= w_grant1;
                        r_wdat  <= w_grant_dat;
                        r_load  <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_START;
                end
                S_WAIT_START, S_WAIT_DONE: begin
                    r_cnt <= r_cnt + 16'd1;
                    if (w_started) begin
                        r_state <= S_WAIT_DONE;
                    end
                    // Acks are registered on the way into DONE so they are
                    // high exactly while the FSM sits in DONE.
                    if (w_to_done) begin
                        r_state <= S_DONE;
                        r_ack0  <= ~r_owner;
                        r_ack1  <= r_owner;
                    end
                    if (w_timeout) begin
                        r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_last_grant <= r_owner;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ack0     = r_ack0;
    assign ack1     = r_ack1;
    assign spi_wdat = r_wdat;
    assign spi_load = r_load;
    assign busy     = r_busy;
    assign err      = r_err;

endmodule

// File: tb/tb_spi_dac_arbiter.sv
module tb_spi_dac_arbiter;

    localparam int DW   = 13;
    localparam int TO_T = 16;

    logic          clk;
    logic          rst;
    logic          req0, req1;
    logic [DW-1:0] wdat0, wdat1;
    logic          ack0, ack1;
    logic [DW-1:0] spi_wdat;
    logic          spi_load;
    logic          spi_csn;
    logic          busy, err;

    logic          t_req0, t_req1;
    logic [DW-1:0] t_wdat0, t_wdat1;
    logic          t_ack0, t_ack1;
    logic [DW-1:0] t_spi_wdat;
    logic          t_spi_load;
    logic          t_spi_csn;
    logic          t_busy, t_err;

    int n_chk = 0;
    int n_fail = 0;
    int mon_chk = 0;
    int mon_fail = 0;
    bit mon_on = 0;
    int cyc = 0;
    int model_last = 1;

    // SPI master models: csn goes low m_d cycles after load, for m_h cycles
    int  m_d = 3, m_h = 26, m_cnt = -1;
    bit  glitch = 0;
    int  t_d = 2, t_h = 5, t_cnt = -1;
    bit  t_en = 0;

    spi_dac_arbiter #(.DW(DW)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .wdat0(wdat0), .ack0(ack0),
        .req1(req1), .wdat1(wdat1), .ack1(ack1),
        .spi_wdat(spi_wdat), .spi_load(spi_load), .spi_csn(spi_csn),
        .busy(busy), .err(err)
    );

    spi_dac_arbiter #(.DW(DW), .TIMEOUT(TO_T)) u_dut_to (
        .clk(clk), .rst(rst),
        .req0(t_req0), .wdat0(t_wdat0), .ack0(t_ack0),
        .req1(t_req1), .wdat1(t_wdat1), .ack1(t_ack1),
        .spi_wdat(t_spi_wdat), .spi_load(t_spi_load), .spi_csn(t_spi_csn),
        .busy(t_busy), .err(t_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        spi_csn = 1;
        forever begin
            @(negedge clk);
            if (spi_load) m_cnt = 0;
            else if (m_cnt >= 0) m_cnt = m_cnt + 1;
            if (m_cnt >= m_d + m_h) m_cnt = -1;
            spi_csn = !((m_cnt >= m_d) || glitch);
        end
    end

    initial begin
        t_spi_csn = 1;
        forever begin
            @(negedge clk);
            if (t_spi_load) t_cnt = 0;
            else if (t_cnt >= 0) t_cnt = t_cnt + 1;
            if (t_cnt >= t_d + t_h) t_cnt = -1;
            t_spi_csn = !(t_en && (t_cnt >= t_d));
        end
    end

    // Per-cycle protocol checks: load only right after leaving idle, acks
    // exclusive and only while busy.
    initial begin
        logic pb, tpb;
        pb = 0;
        tpb = 0;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                mon_chk++;
                if (spi_load && !(busy && !pb)) begin
                    mon_fail++;
                    $display("FAIL load_only_in_load: cycle %0d spi_load=%b busy=%b prev_busy=%b (required load only on first busy cycle)", cyc, spi_load, busy, pb);
                end
                mon_chk++;
                if (ack0 && ack1) begin
                    mon_fail++;
                    $display("FAIL ack_exclusive: cycle %0d ack0=%b ack1=%b (required never both)", cyc, ack0, ack1);
                end
                mon_chk++;
                if ((ack0 || ack1) && !busy) begin
                    mon_fail++;
                    $display("FAIL ack_only_in_done: cycle %0d ack while busy=%b (required busy=1)", cyc, busy);
                end
                mon_chk++;
                if ((t_spi_load && !(t_busy && !tpb)) || (t_ack0 && t_ack1)) begin
                    mon_fail++;
                    $display("FAIL to_protocol: cycle %0d load=%b ack0=%b ack1=%b busy=%b prev_busy=%b", cyc, t_spi_load, t_ack0, t_ack1, t_busy, tpb);
                end
            end
            pb = busy;
            tpb = t_busy;
        end
    end

    // Watches the main arbiter until the next ack (or the cycle budget runs out).
    task automatic observe(input int max_cyc, input bit drop, output int load_c,
                           output logic [DW-1:0] wd_load, output int ack_c, output int who);
        load_c = -1;
        ack_c = -1;
        who = -1;
        wd_load = '0;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (spi_load && load_c < 0) begin
                load_c = cyc;
                wd_load = spi_wdat;
            end
            if (ack0 || ack1) begin
                ack_c = cyc;
                who = ack1 ? 1 : 0;
                if (drop) begin
                    req0 = 0;
                    req1 = 0;
                end
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({spi_load, ack0, ack1, busy, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: load/ack0/ack1/busy/err=%b required 00000", {spi_load, ack0, ack1, busy, err});
        end
        n_chk++;
        if (spi_wdat !== '0) begin
            n_fail++;
            $display("FAIL reset_wdat: got %0h required 0", spi_wdat);
        end
        n_chk++;
        if ({t_spi_load, t_ack0, t_ack1, t_busy, t_err, t_spi_wdat} !== '0) begin
            n_fail++;
            $display("FAIL reset_to_dut: outputs not all zero");
        end
        rst = 0;
        model_last = 1;
        mon_on = 1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lc, ac, who, c_req;
        logic [DW-1:0] wd;
        m_d = 3;
        m_h = 26;
        wdat0 = 13'h0155;
        req0 = 1;
        c_req = cyc;
        observe(80, 1, lc, wd, ac, who);
        n_chk++;
        if (lc !== c_req + 1) begin
            n_fail++;
            $display("FAIL single_load_cycle: got %0d required %0d", lc, c_req + 1);
        end
        n_chk++;
        if (wd !== 13'h0155) begin
            n_fail++;
            $display("FAIL single_wdat: got %0h required 155", wd);
        end
        n_chk++;
        if (who !== 0 || ac !== lc + m_d + m_h + 1) begin
            n_fail++;
            $display("FAIL single_ack: owner %0d at cycle %0d required owner 0 at %0d", who, ac, lc + m_d + m_h + 1);
        end
        model_last = 0;
        @(negedge clk);
        n_chk++;
        if (ack0 !== 0 || err !== 0) begin
            n_fail++;
            $display("FAIL single_after: ack0=%b err=%b required 0 0", ack0, err);
        end
    endtask

    task automatic test_data_stable();
        logic [DW-1:0] a;
        int lc, ac, bad;
        a = DW'($urandom);
        m_d = 2;
        m_h = 20;
        wdat0 = a;
        req0 = 1;
        lc = -1;
        ac = -1;
        bad = 0;
        for (int k = 0; k < 60 && ac < 0; k++) begin
            @(negedge clk);
            if (spi_load && lc < 0) lc = cyc;
            if (lc >= 0 && cyc == lc + 1) req0 = 0;       // drop after grant
            if (lc >= 0 && cyc == lc + 6) wdat0 = ~a;     // change during WAIT_DONE
            if (lc >= 0 && spi_wdat !== a) bad++;
            if (ack0 || ack1) ac = cyc;
        end
        n_chk++;
        if (ac !== lc + m_d + m_h + 1 || lc < 0) begin
            n_fail++;
            $display("FAIL dropped_req_ack: ack cycle %0d required %0d", ac, lc + m_d + m_h + 1);
        end
        n_chk++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL wdat_stable: %0d cycles spi_wdat differed from %0h", bad, a);
        end
        model_last = 0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (spi_wdat !== a || busy !== 0) begin
            n_fail++;
            $display("FAIL wdat_hold_idle: spi_wdat=%0h busy=%b required %0h 0", spi_wdat, busy, a);
        end
    endtask

    task automatic test_contention();
        int lc, ac, who, exp_o;
        logic [DW-1:0] wd;
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_last = 1;
        m_d = 1 + int'($urandom_range(0, 4));
        m_h = 1 + int'($urandom_range(0, 10));
        wdat0 = DW'($urandom);
        wdat1 = DW'($urandom);
        req0 = 1;
        req1 = 1;
        for (int t = 0; t < 4; t++) begin
            observe(60, 0, lc, wd, ac, who);
            exp_o = 1 - model_last;
            n_chk++;
            if (who !== exp_o || wd !== (exp_o == 1 ? wdat1 : wdat0) || ac !== lc + m_d + m_h + 1) begin
                n_fail++;
                $display("FAIL contention_%0d: owner %0d data %0h ack %0d required owner %0d data %0h ack %0d",
                         t, who, wd, ac, exp_o, (exp_o == 1 ? wdat1 : wdat0), lc + m_d + m_h + 1);
            end
            model_last = exp_o;
        end
        req0 = 0;
        req1 = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        int lc, ac, who, exp_o, nbad;
        bit r0, r1;
        logic [DW-1:0] wd, exp_d;
        nbad = 0;
        for (int t = 0; t < 16; t++) begin
            glitch = ($urandom_range(0, 1) == 1);
            repeat (1 + $urandom_range(0, 2)) @(negedge clk);
            glitch = 0;
            @(negedge clk);
            n_chk++;
            if (busy !== 0) begin
                n_fail++;
                $display("FAIL idle_glitch_%0d: busy=%b required 0", t, busy);
            end
            r0 = ($urandom_range(0, 1) == 1);
            r1 = ($urandom_range(0, 1) == 1);
            if (!r0 && !r1) r0 = 1;
            m_d = 1 + int'($urandom_range(0, 5));
            m_h = 1 + int'($urandom_range(0, 11));
            wdat0 = DW'($urandom);
            wdat1 = DW'($urandom);
            exp_o = (r0 && r1) ? 1 - model_last : (r1 ? 1 : 0);
            exp_d = (exp_o == 1) ? wdat1 : wdat0;
            req0 = r0;
            req1 = r1;
            observe(60, 1, lc, wd, ac, who);
            n_chk++;
            if (who !== exp_o || wd !== exp_d || ac !== lc + m_d + m_h + 1) begin
                n_fail++;
                nbad++;
                $display("FAIL random_%0d: owner %0d data %0h ack %0d required owner %0d data %0h ack %0d",
                         t, who, wd, ac, exp_o, exp_d, lc + m_d + m_h + 1);
            end
            model_last = exp_o;
        end
        n_chk++;
        if (err !== 0) begin
            n_fail++;
            $display("FAIL main_err: got %b required 0", err);
        end
    endtask

    task automatic test_reset_mid();
        int lc, ac, who, nack;
        logic [DW-1:0] wd, d1;
        m_d = 2;
        m_h = 30;
        wdat0 = DW'($urandom);
        req0 = 1;
        lc = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (spi_load && lc < 0) lc = cyc;
            if (lc >= 0 && cyc == lc + 6) break;
        end
        rst = 1;
        req0 = 0;
        @(negedge clk);
        n_chk++;
        if ({spi_load, ack0, ack1, busy, err} !== 5'b0 || spi_wdat !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: load/ack0/ack1/busy/err=%b wdat=%0h required all 0",
                     {spi_load, ack0, ack1, busy, err}, spi_wdat);
        end
        rst = 0;
        model_last = 1;
        nack = 0;
        repeat (45) begin
            @(negedge clk);
            if (ack0 || ack1 || busy) nack++;
        end
        n_chk++;
        if (nack !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_ack: %0d cycles with ack/busy required 0", nack);
        end
        m_d = 3;
        m_h = 7;
        d1 = DW'($urandom);
        wdat1 = d1;
        req1 = 1;
        observe(60, 1, lc, wd, ac, who);
        n_chk++;
        if (who !== 1 || wd !== d1 || ac !== lc + m_d + m_h + 1) begin
            n_fail++;
            $display("FAIL reset_mid_next: owner %0d data %0h ack %0d required owner 1 data %0h ack %0d",
                     who, wd, ac, d1, lc + m_d + m_h + 1);
        end
        model_last = 1;
    endtask

    task automatic test_timeout();
        int lc, ac, who;
        logic e_before, e_at;
        logic [DW-1:0] d0, d1, wd;
        t_en = 0;
        d0 = DW'($urandom);
        t_wdat0 = d0;
        t_req0 = 1;
        lc = -1;
        ac = -1;
        who = -1;
        e_before = 1'bx;
        e_at = 1'bx;
        wd = '0;
        for (int k = 0; k < 60 && ac < 0; k++) begin
            @(negedge clk);
            if (t_spi_load && lc < 0) begin
                lc = cyc;
                wd = t_spi_wdat;
            end
            if (lc >= 0 && cyc == lc + TO_T) e_before = t_err;
            if (t_ack0 || t_ack1) begin
                ac = cyc;
                who = t_ack1 ? 1 : 0;
                e_at = t_err;
                t_req0 = 0;
            end
        end
        n_chk++;
        if (who !== 0 || ac !== lc + 1 + TO_T || lc < 0) begin
            n_fail++;
            $display("FAIL timeout_ack: owner %0d at %0d required owner 0 at %0d", who, ac, lc + 1 + TO_T);
        end
        n_chk++;
        if (e_before !== 0 || e_at !== 1 || wd !== d0) begin
            n_fail++;
            $display("FAIL timeout_err: err before %b at ack %b wdat %0h required 0 1 %0h", e_before, e_at, wd, d0);
        end
        repeat (20) @(negedge clk);
        n_chk++;
        if (t_err !== 1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b required 1", t_err);
        end
        t_en = 1;
        t_d = 2;
        t_h = 5;
        d1 = DW'($urandom);
        t_wdat1 = d1;
        t_req1 = 1;
        lc = -1;
        ac = -1;
        who = -1;
        for (int k = 0; k < 60 && ac < 0; k++) begin
            @(negedge clk);
            if (t_spi_load && lc < 0) begin
                lc = cyc;
                wd = t_spi_wdat;
            end
            if (t_ack0 || t_ack1) begin
                ac = cyc;
                who = t_ack1 ? 1 : 0;
                t_req1 = 0;
            end
        end
        n_chk++;
        if (who !== 1 || wd !== d1 || ac !== lc + t_d + t_h + 1 || t_err !== 1) begin
            n_fail++;
            $display("FAIL timeout_next: owner %0d data %0h ack %0d err %b required owner 1 data %0h ack %0d err 1",
                     who, wd, ac, t_err, d1, lc + t_d + t_h + 1);
        end
    endtask

    initial begin
        rst = 1;
        req0 = 0;
        req1 = 0;
        wdat0 = '0;
        wdat1 = '0;
        t_req0 = 0;
        t_req1 = 0;
        t_wdat0 = '0;
        t_wdat1 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_data_stable();
        test_contention();
        test_random();
        test_reset_mid();
        test_timeout();
        repeat (3) @(negedge clk);
        mon_on = 0;
        @(negedge clk);
        n_chk += mon_chk;
        n_fail += mon_fail;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_dac_arbiter.md
SPI_DAC_ARBITER -- requirements
Module: spi_dac_arbiter

Interface
REQ-001 Parameter DW, default 13: DAC word width in bits.
REQ-002 Parameter TIMEOUT, default 4096: maximum cycles a transfer may take before it is aborted; legal range 2..65535.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0  input  1  requester 0 (VCO ramp) write request; held high until ack0.
REQ-006 wdat0  input  DW  requester 0 data word; stable while req0 is high.
REQ-007 ack0  output  1  one-cycle pulse when requester 0's write has completed or been aborted.
REQ-008 req1, wdat1, ack1: same as REQ-005..007 for requester 1 (AGC).
REQ-009 spi_wdat  output  DW  registered word presented to the shared SPI write master.
REQ-010 spi_load  output  1  one-cycle load strobe to the SPI master.
REQ-011 spi_csn  input  1  chip-select monitored from the SPI master; low means a transfer is in progress.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  sticky timeout flag; cleared only by rst.

Function
REQ-014 The FSM SHALL have exactly these states: IDLE, LOAD, WAIT_START, WAIT_DONE, DONE.
REQ-015 IDLE, no request: stay in IDLE.
REQ-016 IDLE, any request: grant one requester, register its wdat into spi_wdat, record it as owner, go to LOAD.
REQ-017 Arbitration SHALL be round-robin: with both requests high, grant the requester other than last_grant; with one request high, grant that requester.
REQ-018 LOAD: spi_load=1 for exactly this one cycle, then WAIT_START; the first load occurs the cycle after the request is sampled in IDLE.
REQ-019 WAIT_START: go to WAIT_DONE on the first cycle spi_csn is sampled 0.
REQ-020 WAIT_DONE: go to DONE on the first cycle spi_csn is sampled 1.
REQ-021 DONE: assert the owner's ack for exactly one cycle, set last_grant to the owner, go to IDLE; requests are ignored in DONE.
REQ-022 A timeout counter SHALL clear on entry to WAIT_START and increment on each cycle spent in WAIT_START or WAIT_DONE.
REQ-023 If the counter reaches TIMEOUT-1 while still waiting, the FSM SHALL set err and go to DONE; the owner is still acked.
REQ-024 spi_wdat SHALL change only on a grant in IDLE, so it stays stable for the whole transfer.
REQ-025 ack0 and ack1 SHALL never be high in the same cycle, and each SHALL be high only in DONE.
REQ-026 A request that drops before being granted is not served and produces no ack.
REQ-027 A request that drops after being granted does not abort the transfer; its ack is still issued.
REQ-028 A requester that re-asserts its request immediately after its ack SHALL lose to a pending other requester (round-robin fairness).
REQ-029 A spi_csn glitch while in IDLE, LOAD or DONE SHALL be ignored.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst SHALL force: state=IDLE, spi_load=0, spi_wdat=0, ack0=0, ack1=0, busy=0, err=0, last_grant=1 (so requester 0 wins the first tie), timeout counter=0.
REQ-032 rst asserted mid-transfer SHALL abandon the transfer without issuing any ack; on the cycle after rst deasserts the block is in IDLE.

Verification
REQ-033 Single request: req0=1, wdat0=0x0155; SPI model pulls csn low 3 cycles after load and holds it 26 cycles -> spi_load pulses one cycle after req0 is sampled, spi_wdat=0x0155, one ack0 pulse after csn rises, err=0.
REQ-034 Contention: req0 and req1 raised in the same cycle after reset -> requester 0 served first, then requester 1; both re-assert immediately -> order 0,1,0,1 over 4 transfers.
REQ-035 Timeout: TIMEOUT=16, csn held high forever -> ack0 pulses 16 cycles after entering WAIT_START, err=1 and stays 1; the next request is still served normally.
REQ-036 Reset mid-transfer: rst asserted during WAIT_DONE -> no ack is issued, all outputs take their REQ-031 values, a following req1 is served normally.
REQ-037 Data stability: wdat0 changed while in WAIT_DONE -> spi_wdat unchanged until the next grant.
REQ-038 A bench assertion SHALL check on every cycle that spi_load is high only in LOAD and that ack0 and ack1 are never high together.
